// File: rtl/mem_resp_pkg.sv
// Shared constants for the line-fill memory responder: FSM encodings,
// line width and the seed of the optional latency-jitter LFSR.
package mem_resp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t BUSY = 2'b01;
    localparam state_t RESP = 2'b10;

    localparam int LINE_W = 128;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/line_mem_array.sv
// Single-port synchronous line RAM. One-cycle read, and a write returns the
// newly written line on the same edge. Contents have no reset; only the read
// register clears.
module line_mem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // storage write, kept reset-free so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    // read register: new data on write, stored line on read, holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[idx];
        end
    end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the I-cache line-fill interface. Serves one
// line read or write at a time after a programmable latency and pulses
// mem_ready for one cycle.
// Optional build macro: RANDOM_LATENCY_EN adds 0..3 cycles of LFSR jitter.
//
//  state | meaning
//  IDLE  | waiting for mem_read or mem_write
//  BUSY  | request latched, latency counter running
//  RESP  | mem_ready high, mem_rdata valid
module line_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = LINE_W,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready
);

`ifdef RANDOM_LATENCY_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    state_t                  state, next_state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        eff_lat;
    logic [DEPTH_LOG2-1:0]   lat_idx;
    logic                    lat_we;
    logic [DATA_W-1:0]       lat_wdata;
    logic                    req;

    logic                    arr_en;
    logic                    arr_we;
    logic [DEPTH_LOG2-1:0]   arr_idx;
    logic [DATA_W-1:0]       arr_wdata;

    // upper address bits alias onto the array index
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    assign req = mem_read | mem_write;

`ifdef RANDOM_LATENCY_EN
    logic [15:0] lfsr;

    assign eff_lat = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);

    // jitter source, advanced once per accepted request
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            lfsr <= LFSR_SEED;
        end else if (state == IDLE && req) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`else
    assign eff_lat = CNT_W'(LATENCY);
`endif

    // state register, latency counter and request latches
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                cnt       <= eff_lat - CNT_W'(1);
                lat_idx   <= mem_addr[DEPTH_LOG2-1:0];
                lat_we    <= mem_write;
                lat_wdata <= mem_wdata;
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (eff_lat == CNT_W'(1)) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // outputs and array access on the edge entering RESP; a latency of one
    // enters RESP straight from IDLE, before the latches are loaded
    always_comb begin
        mem_ready = (state == RESP);
        arr_en    = (state != RESP) && (next_state == RESP) && !proc_reset;
        if (state == IDLE) begin
            arr_we    = mem_write;
            arr_idx   = mem_addr[DEPTH_LOG2-1:0];
            arr_wdata = mem_wdata;
        end else begin
            arr_we    = lat_we;
            arr_idx   = lat_idx;
            arr_wdata = lat_wdata;
        end
    end

    line_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (proc_reset),
        .en    (arr_en),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder with hand-computed expected values.
// Build with RANDOM_LATENCY_EN defined to check the jittered latency window.
module tb_line_mem_responder;

    localparam logic [127:0] PRE  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] L20  = 128'h2020_2020_AAAA_5555_0000_FFFF_1234_5678;
    localparam logic [127:0] JUNK = 128'hBAD0_BAD1_BAD2_BAD3_BAD4_BAD5_BAD6_BAD7;
    localparam logic [127:0] ALI  = 128'hA11A_5000_0000_0000_0000_0000_0000_0100;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    line_mem_responder dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic lat_ok(input int lat);
`ifdef RANDOM_LATENCY_EN
        return (lat >= 4) && (lat <= 7);
`else
        return lat == 4;
`endif
    endfunction

    // one request held for a single accepting edge; lat is the cycle offset
    // of the mem_ready pulse (0 if none within budget)
    task automatic do_req(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] wd, input logic [27:0] addr_t1,
                          output int lat, output logic [127:0] rdata);
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = addr_t1;
        mem_wdata = JUNK;
        lat   = 0;
        rdata = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                lat   = k;
                rdata = mem_rdata;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            chk("ready_one_cycle", {127'd0, mem_ready}, 128'd0);
        end
    endtask

    int           lat;
    logic [127:0] rd;
    int           n_rdy;
    int           p1, p2;
    int           bad_lat;

    initial begin
        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {127'd0, mem_ready}, 128'd0);
        chk("rst_rdata", mem_rdata, 128'd0);
        chk("rst_state", {126'd0, dut.state}, 128'd0);
        proc_reset = 1'b0;

        // preload line 0x10 and read it back
        do_req(1'b0, 1'b1, 28'h10, PRE, 28'h10, lat, rd);
        chk("preload_lat", {127'd0, lat_ok(lat)}, 128'd1);
        do_req(1'b1, 1'b0, 28'h10, '0, 28'h10, lat, rd);
        chk("read10_lat", {127'd0, lat_ok(lat)}, 128'd1);
        chk("read10_data", rd, PRE);

        // write then read 0x05
        do_req(1'b0, 1'b1, 28'h05, DEAD, 28'h05, lat, rd);
        chk("write05_lat", {127'd0, lat_ok(lat)}, 128'd1);
        chk("write05_data", rd, DEAD);
        do_req(1'b1, 1'b0, 28'h05, '0, 28'h05, lat, rd);
        chk("read05_lat", {127'd0, lat_ok(lat)}, 128'd1);
        chk("read05_data", rd, DEAD);

        // address change after acceptance is ignored
        do_req(1'b0, 1'b1, 28'h20, L20, 28'h20, lat, rd);
        do_req(1'b1, 1'b0, 28'h10, '0, 28'h20, lat, rd);
        chk("addr_chg_lat", {127'd0, lat_ok(lat)}, 128'd1);
        chk("addr_chg_data", rd, PRE);

        // reset while BUSY drops the pending write to 0x10
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h10;
        mem_wdata = JUNK;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        proc_reset = 1'b1;
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        n_rdy = 0;
        for (int k = 3; k <= 10; k++) begin
            @(negedge clk);
            if (mem_ready) n_rdy++;
        end
        chk("midrst_no_ready", 128'(n_rdy), 128'd0);
        chk("midrst_state", {126'd0, dut.state}, 128'd0);
        chk("midrst_rdata", mem_rdata, 128'd0);
        do_req(1'b1, 1'b0, 28'h10, '0, 28'h10, lat, rd);
        chk("midrst_read10", rd, PRE);

        // read and write together: write wins, single response
        do_req(1'b1, 1'b1, 28'h07, 128'h1, 28'h07, lat, rd);
        chk("rw_lat", {127'd0, lat_ok(lat)}, 128'd1);
        chk("rw_data", rd, 128'h1);
        do_req(1'b1, 1'b0, 28'h07, '0, 28'h07, lat, rd);
        chk("rw_array", rd, 128'h1);

        // upper address bits alias
        do_req(1'b0, 1'b1, 28'h100, ALI, 28'h100, lat, rd);
        do_req(1'b1, 1'b0, 28'h000, '0, 28'h000, lat, rd);
        chk("alias_0x100", rd, ALI);
        do_req(1'b1, 1'b0, 28'hF10, '0, 28'hF10, lat, rd);
        chk("alias_0xF10", rd, PRE);

`ifdef RANDOM_LATENCY_EN
        bad_lat = 0;
        for (int i = 0; i < 100; i++) begin
            do_req(1'b1, 1'b0, 28'h05, '0, 28'h05, lat, rd);
            if (!lat_ok(lat) || rd !== DEAD) bad_lat++;
        end
        chk("rand_lat_window", 128'(bad_lat), 128'd0);
`else
        // request held high: second fill starts the cycle after RESP
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 28'h05;
        @(posedge clk);
        p1 = 0;
        p2 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                if (p1 == 0) p1 = k;
                else if (p2 == 0) p2 = k;
            end
            if (k == 10) mem_read = 1'b0;
        end
        chk("b2b_first", 128'(p1), 128'd4);
        chk("b2b_second", 128'(p2), 128'd9);
        chk("b2b_data", mem_rdata, DEAD);
        repeat (6) @(negedge clk);
        chk("b2b_idle", {126'd0, dut.state}, 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
